dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port (combinational read, synchronous write) between the
//  3-stage core's EX-stage load/store port and a sensor-sample DMA port. Core has priority;
//  a wait counter bounds DMA starvation by forcing one DMA slot and stalling the core.

---
 rtl/dmem_port_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single DMEM port between the core EX-stage port (priority) and a DMA port,
// with a bounded DMA wait. Optional address window checking under DMEM_DMA_WINDOW_EN.
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          core_en,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_valid,
  output logic          dma_ready,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_rsp_valid,
  output logic [DW-1:0] dma_rsp_data,
  output logic          dma_rsp_err,
`ifdef DMEM_DMA_WINDOW_EN
  input  logic [AW-1:0] dma_win_base,
  input  logic [AW-1:0] dma_win_size,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {PRI_CORE, PRI_DMA} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dma_grant;
  logic             dma_err;
  logic             dma_mem;
  logic             core_use;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [DW-1:0]    rsp_data_q;

`ifdef DMEM_DMA_WINDOW_EN
  // Subtract first so base+size overflowing AW cannot wrap the compare.
  assign dma_err = (dma_addr < dma_win_base) || ((dma_addr - dma_win_base) >= dma_win_size);
`else
  assign dma_err = 1'b0;
`endif

  always_comb begin
    dma_grant = 1'b0;
    if (resetn) begin
      if (state == PRI_DMA && dma_valid) dma_grant = 1'b1;
      else if (!core_en)                 dma_grant = dma_valid;
    end
  end

  // A rejected DMA request never touches memory, so the core may take the port that cycle.
  assign dma_mem    = dma_grant && !dma_err;
  assign core_use   = resetn && core_en && !dma_mem;
  assign core_stall = resetn && core_en && dma_mem;
  assign dma_ready  = dma_grant;
  assign core_rdata = mem_rdata;

  assign mem_en    = dma_mem || core_use;
  assign mem_we    = dma_mem ? dma_we    : (core_use && core_we);
  assign mem_addr  = dma_mem ? dma_addr  : core_addr;
  assign mem_wdata = dma_mem ? dma_wdata : core_wdata;

  assign cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= PRI_CORE;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= dma_grant && (!dma_we || dma_err);
      rsp_err_q   <= dma_grant && dma_err;
      if (dma_grant) rsp_data_q <= dma_err ? '0 : mem_rdata;
      case (state)
        PRI_CORE: begin
          if (dma_grant || !dma_valid) begin
            wait_cnt <= '0;
          end else begin
            // Conflict: the core won; force the DMA slot once the bound is reached.
            wait_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) state <= PRI_DMA;
          end
        end
        default: begin
          state    <= PRI_CORE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Gating by resetn drops a pending response as soon as reset is applied.
  assign dma_rsp_valid = resetn && rsp_valid_q;
  assign dma_rsp_err   = resetn && rsp_err_q;
  assign dma_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cases then random traffic against a behavioural model.
// Define DMEM_DMA_WINDOW_EN to also exercise the address window.
module tb_dmem_port_arbiter;
  localparam int AW = 32, DW = 32, MAX_WAIT = 4;

  logic clk = 1'b0;
  logic resetn;
  logic core_en, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic core_stall;
  logic dma_valid, dma_ready, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic dma_rsp_valid, dma_rsp_err;
  logic [DW-1:0] dma_rsp_data;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_DMA_WINDOW_EN
  logic [AW-1:0] dma_win_base, dma_win_size;
`endif

  int checks = 0, errors = 0;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
    .dma_rsp_err(dma_rsp_err),
`ifdef DMEM_DMA_WINDOW_EN
    .dma_win_base(dma_win_base), .dma_win_size(dma_win_size),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: combinational read, synchronous write, preload port for the bench.
  logic [DW-1:0] mem_arr [64];
  logic          ld_en;
  logic [5:0]    ld_idx;
  logic [DW-1:0] ld_val;
  assign mem_rdata = mem_arr[mem_addr[7:2]];
  always @(posedge clk) begin
    if (ld_en) mem_arr[ld_idx] <= ld_val;
    else if (mem_en && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: DMA wins if the core is idle or it has already lost MAX_WAIT-1 cycles in a row.
  logic [DW-1:0] ref_mem [64];
  int            losses = 0;
  logic          p_valid = 1'b0, p_err = 1'b0, m_acc = 1'b0;
  logic [DW-1:0] p_data = '0;

  always @(negedge clk) begin
    logic dwin, err, dmem, cserve;
    chk("rsp_valid", dma_rsp_valid, resetn ? p_valid : 1'b0);
    if (resetn && p_valid) begin
      chk("rsp_err", dma_rsp_err, p_err);
      chk("rsp_data", dma_rsp_data, p_data);
    end
    m_acc = 1'b0;
    if (ld_en) ref_mem[ld_idx] = ld_val;
    if (!resetn) begin
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_dma_ready", dma_ready, 1'b0);
      chk("rst_core_stall", core_stall, 1'b0);
      p_valid = 1'b0;
      losses  = 0;
    end else begin
      dwin = dma_valid && (!core_en || losses >= MAX_WAIT - 1);
`ifdef DMEM_DMA_WINDOW_EN
      err = (dma_addr < dma_win_base) || (dma_addr >= dma_win_base + dma_win_size);
`else
      err = 1'b0;
`endif
      dmem   = dwin && !err;
      cserve = core_en && !dmem;
      chk("dma_ready", dma_ready, dwin);
      chk("core_stall", core_stall, core_en && !cserve);
      chk("mem_en", mem_en, dmem || cserve);
      if (dmem) begin
        chk("mem_we", mem_we, dma_we);
        chk("mem_addr", mem_addr, dma_addr);
        if (dma_we) chk("mem_wdata", mem_wdata, dma_wdata);
      end else if (cserve) begin
        chk("mem_we", mem_we, core_we);
        chk("mem_addr", mem_addr, core_addr);
        if (core_we) chk("mem_wdata", mem_wdata, core_wdata);
        else chk("core_rdata", core_rdata, ref_mem[core_addr[7:2]]);
      end
      p_valid = dwin && (!dma_we || err);
      p_err   = dwin && err;
      p_data  = err ? '0 : ref_mem[dma_addr[7:2]];
      losses  = (dma_valid && !dwin) ? losses + 1 : 0;
      if (dmem && dma_we) ref_mem[dma_addr[7:2]] = dma_wdata;
      else if (cserve && core_we) ref_mem[core_addr[7:2]] = core_wdata;
      m_acc = dwin;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_core(input logic en, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_en = en; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_valid = v; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    logic dreq;
    resetn = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    set_core(0, 0, '0, '0); set_dma(0, 0, '0, '0);
`ifdef DMEM_DMA_WINDOW_EN
    dma_win_base = 32'h0; dma_win_size = 32'h1000;
`endif
    cyc();
    for (int i = 0; i < 64; i++) begin
      ld_en = 1'b1; ld_idx = 6'(i);
      ld_val = (i == 4) ? 32'hDEADBEEF : $urandom;
      cyc();
    end
    ld_en = 1'b0;
    set_core(1, 1, 32'h10, 32'h1);
    set_dma(1, 1, 32'h20, 32'h2);
    #3;
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_stall", core_stall, 1'b0);
    chk("reset_ready", dma_ready, 1'b0);
    chk("reset_rsp", dma_rsp_valid, 1'b0);
    cyc();
    resetn = 1'b1;

    // Core-only load
    set_core(1, 0, 32'h10, '0); set_dma(0, 0, '0, '0);
    #3 chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_stall", core_stall, 1'b0);
    cyc();

    // DMA-only write then read
    set_core(0, 0, '0, '0); set_dma(1, 1, 32'h20, 32'h12345678);
    #3 chk("t2_wr_ready", dma_ready, 1'b1);
    cyc();
    dma_we = 1'b0;
    #3 chk("t2_rd_ready", dma_ready, 1'b1);
    chk("t2_no_wr_rsp", dma_rsp_valid, 1'b0);
    cyc();
    set_dma(0, 0, '0, '0);
    #3 chk("t2_rsp_valid", dma_rsp_valid, 1'b1);
    chk("t2_rsp_data", dma_rsp_data, 32'h12345678);
    cyc();
    #3 chk("t2_rsp_once", dma_rsp_valid, 1'b0);
    cyc();

    // Persistent conflict: DMA forced on the 4th cycle
    set_core(1, 0, 32'h0, '0); set_dma(1, 0, 32'h20, '0);
    for (int k = 1; k <= 4; k++) begin
      #3 chk("t3_ready", dma_ready, k == 4);
      chk("t3_stall", core_stall, k == 4);
      cyc();
    end
    set_dma(0, 0, '0, '0);
    #3 chk("t3_rsp_data", dma_rsp_data, 32'h12345678);
    cyc();

    // Core drops in cycle 2; a fresh conflict then needs the full 4 cycles again
    set_dma(1, 0, 32'h20, '0);
    #3 chk("t4_c1_ready", dma_ready, 1'b0);
    cyc();
    core_en = 1'b0;
    #3 chk("t4_c2_ready", dma_ready, 1'b1);
    chk("t4_c2_stall", core_stall, 1'b0);
    cyc();
    core_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #3 chk("t4_refill_ready", dma_ready, k == 4);
      cyc();
    end
    set_dma(0, 0, '0, '0);
    cyc();

    // Reset in the cycle after a DMA read accept
    set_core(0, 0, '0, '0); set_dma(1, 0, 32'h20, '0);
    cyc();
    set_dma(0, 0, '0, '0); resetn = 1'b0;
    #3 chk("t5_rsp_dropped", dma_rsp_valid, 1'b0);
    cyc();
    resetn = 1'b1;
    #3 chk("t5_rsp_after", dma_rsp_valid, 1'b0);
    chk("t5_stall", core_stall, 1'b0);
    cyc();

`ifdef DMEM_DMA_WINDOW_EN
    dma_win_base = 32'h100; dma_win_size = 32'h40;
    set_dma(1, 0, 32'h140, '0);
    #3 chk("t6_mem_en", mem_en, 1'b0);
    chk("t6_ready", dma_ready, 1'b1);
    cyc();
    set_dma(0, 0, '0, '0);
    #3 chk("t6_rsp_valid", dma_rsp_valid, 1'b1);
    chk("t6_rsp_err", dma_rsp_err, 1'b1);
    chk("t6_rsp_data", dma_rsp_data, 32'h0);
    cyc();
    dma_win_base = 32'h40; dma_win_size = 32'h80;
`endif

    // Random traffic; a DMA request is held until the model says it was accepted
    dreq = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      set_core($urandom_range(0, 99) < 70, $urandom_range(0, 1),
               {24'h0, 6'($urandom), 2'b00}, $urandom);
      if (!dreq || m_acc) begin
        dreq = ($urandom_range(0, 99) < 40);
        set_dma(dreq, $urandom_range(0, 1), {24'h0, 6'($urandom), 2'b00}, $urandom);
      end
      cyc();
    end
    resetn = 1'b1;
    set_core(0, 0, '0, '0); set_dma(0, 0, '0, '0);
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
